// File: rtl/aes_cbc_ctrl_pkg.sv
// aes_cbc_ctrl_pkg: AES request/response types, function encodings and CBC sequencer states
package aes_cbc_ctrl_pkg;
  localparam int Nk = 4;
  localparam int KW = 32 * Nk;
  typedef enum logic [1:0] {
    AES_IDLE    = 2'h0,
    AES_KEXP    = 2'h1,
    AES_CIPHER  = 2'h2,
    AES_ICIPHER = 2'h3
  } aes_func_e;
  typedef struct packed {
    logic          enable;
    aes_func_e     func;
    logic [KW-1:0] key;
    logic [127:0]  data;
  } aes_in_type;
  typedef struct packed {
    logic         ready;
    logic [127:0] result;
  } aes_out_type;
  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ISSUE, S_WAIT, S_OUT} cbc_state_e;
endpackage

// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: ECB/CBC mode sequencer in front of the aes core, with key expansion
// triggering, IV/chain register and a response watchdog.
module aes_cbc_ctrl
  import aes_cbc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          key_load,
  input  logic [KW-1:0] key,
  input  logic          iv_load,
  input  logic [127:0]  iv,
  input  logic          mode,
  input  logic          dir,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy,
  output logic          key_valid,
  output logic          timeout_err,
  output aes_in_type    aes_req,
  input  aes_out_type   aes_rsp
);
  localparam int WW = $clog2(TIMEOUT);

  cbc_state_e    state_q;
  logic [KW-1:0] key_q;
  logic [127:0]  chain_q, raw_q, data_q, out_data_q;
  logic          mode_q, dir_q, enable_q, out_valid_q, key_valid_q, timeout_q;
  aes_func_e     func_q;
  logic [WW-1:0] wdog_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      chain_q     <= '0;
      raw_q       <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
      enable_q    <= 1'b0;
      func_q      <= AES_IDLE;
      out_valid_q <= 1'b0;
      key_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_load) begin
            key_q       <= key;
            key_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            enable_q    <= 1'b1;
            func_q      <= AES_KEXP;
            state_q     <= S_KEXP;
          end else if (iv_load) begin
            chain_q <= iv;
          end else if (in_valid && key_valid_q) begin
            raw_q    <= in_data;
            mode_q   <= mode;
            dir_q    <= dir;
            // only CBC encrypt whitens the plaintext before the cipher
            data_q   <= (mode && !dir) ? in_data ^ chain_q : in_data;
            enable_q <= 1'b1;
            func_q   <= dir ? AES_ICIPHER : AES_CIPHER;
            state_q  <= S_ISSUE;
          end
        end
        S_KEXP: begin
          enable_q    <= 1'b0;
          func_q      <= AES_IDLE;
          key_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_ISSUE: begin
          enable_q <= 1'b0;
          func_q   <= AES_IDLE;
          wdog_q   <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          if (aes_rsp.ready) begin
            out_data_q  <= (mode_q && dir_q) ? aes_rsp.result ^ chain_q : aes_rsp.result;
            chain_q     <= !mode_q ? chain_q : dir_q ? raw_q : aes_rsp.result;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && key_valid_q && !key_load && !iv_load;
  assign busy        = state_q != S_IDLE;
  assign key_valid   = key_valid_q;
  assign timeout_err = timeout_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign aes_req     = '{enable: enable_q, func: func_q, key: key_q, data: data_q};
endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
Mode sequencer directly upstream of the aes top. Accepts 128-bit blocks over a valid/ready stream, drives aes_in (enable/func/key/data) and consumes aes_out (ready/result). Applies ECB or CBC chaining and returns results over a valid/ready stream. Owns key-expansion triggering, the IV/chain register and a response watchdog.

Parameters:
TIMEOUT, 64, max cycles in WAIT before aborting the block (>=2)
KW, 32*Nk, key width from aes_const

Ports:
rst  in  1  asynchronous reset, active-low
clk  in  1  clock
key_load  in  1  load key and run expansion
key  in  KW  cipher key
iv_load  in  1  load IV into chain register
iv  in  128  initialisation vector
mode  in  1  0=ECB, 1=CBC; sampled at block accept
dir  in  1  0=encrypt, 1=decrypt; sampled at block accept
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when valid&ready
in_data  in  128  input block
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  128  result block
busy  out  1  state != IDLE
key_valid  out  1  expansion done since last key_load
timeout_err  out  1  sticky watchdog abort flag
aes_req  out  aes_in_type  request to aes top
aes_rsp  in  aes_out_type  response from aes top

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; key/chain/data registers 0; key_valid=0; timeout_err=0.
- States: IDLE, KEXP, ISSUE, WAIT, OUT.
- aes_req.key always driven from the key register. aes_req.data is held from ISSUE through WAIT.
- aes_req.enable is 1 only in KEXP and ISSUE (a one-cycle pulse). func is AES_KEXP or AES_CIPHER/AES_ICIPHER per the latched dir; otherwise AES_IDLE.
- IDLE priority: key_load > iv_load > block accept.
  - key_load: latch key; key_valid<=0; timeout_err<=0; go to KEXP.
  - iv_load: chain<=iv; stay in IDLE.
- in_ready = IDLE & key_valid & ~key_load & ~iv_load (combinational). key_load/iv_load outside IDLE are ignored.
- KEXP (1 cycle): enable=1, func=AES_KEXP. Next cycle: key_valid<=1, go to IDLE.
- Block accept: latch raw=in_data, mode, dir. Operand:
  - CBC encrypt: in_data^chain.
  - CBC decrypt and ECB: in_data.
  - Go to ISSUE.
- ISSUE (1 cycle): enable=1 with operand; wdog<=0; go to WAIT.
- WAIT: enable=0; wdog increments each cycle.
  - On aes_rsp.ready=1: capture out_data.
    - CBC decrypt: result^chain; chain<=raw.
    - CBC encrypt: result; chain<=result.
    - ECB: result; chain unchanged.
    - Go to OUT.
  - If ready is not seen and wdog==TIMEOUT-1: timeout_err<=1, block dropped, chain unchanged, go to IDLE. ready takes priority when both happen in the same cycle.
- aes_rsp.ready outside WAIT is ignored.
- OUT: out_valid=1 with out_data stable until out_ready=1, then go to IDLE. in_ready may rise the next cycle.
- Best-case latency, accept to out_valid: 1 (ISSUE) + aes latency + 1 cycles. No overlap of blocks; one outstanding block.
- Chain register survives key_load; only iv_load or reset change it outside block completion.

Decomposition:
- aes_const gains func encodings: AES_IDLE=2'h0, AES_KEXP=2'h1, AES_CIPHER=2'h2, AES_ICIPHER=2'h3. The aes top uses these same encodings.
- aes_wire reuses aes_in_type/aes_out_type and gains a cbc state enum type.
- No sub-module: the watchdog counter and chaining XOR stay inline.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, ECB encrypt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; ECB decrypt of that -> original plaintext.
- CBC encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f:
  - P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2
- CBC decrypt, same key/IV, of C1, C2 -> P1, P2; check chain equals C2 afterwards.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout; one-cycle out_ready -> IDLE, next block accepted.
- Watchdog: stubbed aes never raises ready, TIMEOUT=8 -> timeout_err=1 after 8 WAIT cycles, no out_valid, chain unchanged; next key_load clears the flag.
- Reset mid-WAIT: rst=0 asynchronously -> all outputs 0 immediately, key_valid=0, in_ready=0 until a new key_load completes.
